prog_loader: RTL

- Upstream feeder for the CPU's memory-load port (address, inst_data, write_instruction, write_data, rst).
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one-cycle write strobes into instruction memory or data memory.
- Holds the CPU in reset while loading and releases it on a RUN command, so a program can be loaded without a testbench poking ports directly.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader_byte_to_word.sv | 32 +++
 rtl/prog_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared command bytes, FSM state encoding and write-target selector for the
// program loader that feeds the CPU memory-load port.
package prog_loader_pkg;

  localparam logic [7:0] CMD_INST = 8'h49;
  localparam logic [7:0] CMD_DATA = 8'h44;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    WORD,
    WRITE,
    RUN
  } state_e;

  typedef enum logic {
    TGT_INST,
    TGT_DATA
  } target_e;

  function automatic logic is_load_cmd(input logic [7:0] b);
    return (b == CMD_INST) || (b == CMD_DATA);
  endfunction

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// Big-endian byte-to-word assembler: the first byte shifted in ends up in bits
// [31:24]; word_valid_o pulses combinationally as the 4th byte arrives.
module byte_to_word
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] word_q;
  logic [1:0]  cnt_q;

  // Only the first three bytes need storage; the 4th is taken straight from the input.
  assign word_o       = {word_q, byte_i};
  assign word_valid_o = en_i && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (en_i) begin
      word_q <= {word_q[15:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses load/run/halt commands, writes assembled
// words into instruction or data memory and holds the CPU in reset meanwhile.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       inst_data,
  output logic              write_instruction,
  output logic              write_data,
  output logic              cpu_rst,
  output logic              busy,
  output logic              error
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_e              state_q;
  target_e             tgt_q;
  logic [7:0]          cnt_hi_q;
  logic [16:0]         remaining_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;
  logic                wr_inst_q;
  logic                wr_data_q;
  logic                cpu_rst_q;
  logic                error_q;
  logic                ready_q;

  logic                fire;
  logic [16:0]         count_w;
  logic [31:0]         word;
  logic                word_valid;

  assign fire    = in_valid && ready_q;
  assign count_w = {1'b0, cnt_hi_q, in_data};

  byte_to_word u_b2w (
    .clk          (clk),
    .rst          (rst),
    .clr_i        ((state_q == CNT_LO) && fire),
    .en_i         ((state_q == WORD) && fire),
    .byte_i       (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // in_ready is registered, so it is derived from the state being entered:
  // low only for the single WRITE cycle (and the cycle after reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      tgt_q       <= TGT_INST;
      cnt_hi_q    <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_inst_q   <= 1'b0;
      wr_data_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      error_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      wr_inst_q <= 1'b0;
      wr_data_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fire) begin
            if (is_load_cmd(in_data)) begin
              tgt_q   <= (in_data == CMD_DATA) ? TGT_DATA : TGT_INST;
              error_q <= 1'b0;
              state_q <= CNT_HI;
            end else if (in_data == CMD_RUN) begin
              error_q   <= 1'b0;
              cpu_rst_q <= 1'b0;
              state_q   <= RUN;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        CNT_HI: begin
          if (fire) begin
            cnt_hi_q <= in_data;
            state_q  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (fire) begin
            if (count_w == 17'd0) begin
              state_q <= IDLE;
            end else if (count_w > MAX_WORDS) begin
              error_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              addr_q      <= '0;
              remaining_q <= count_w;
              state_q     <= WORD;
            end
          end
        end
        WORD: begin
          if (word_valid) begin
            data_q    <= word;
            wr_inst_q <= (tgt_q == TGT_INST);
            wr_data_q <= (tgt_q == TGT_DATA);
            ready_q   <= 1'b0;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          remaining_q <= remaining_q - 17'd1;
          if (remaining_q == 17'd1) begin
            state_q <= IDLE;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= WORD;
          end
        end
        RUN: begin
          if (fire && (in_data == CMD_HALT)) begin
            cpu_rst_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready          = ready_q;
  assign address           = addr_q;
  assign inst_data         = data_q;
  assign write_instruction = wr_inst_q;
  assign write_data        = wr_data_q;
  assign cpu_rst           = cpu_rst_q;
  assign error             = error_q;
  assign busy              = (state_q != IDLE) && (state_q != RUN);

endmodule
